// File: rtl/ballot_input_controller.sv
// Ballot input front end: synchronizes and debounces two candidate buttons,
// arms on an officer strobe and emits a single registered vote or reject pulse per ballot.
module ballot_input_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a,
  input  logic btn_b,
  input  logic ballot_en,
  output logic vote_a,
  output logic vote_b,
  output logic ballot_ready,
  output logic reject
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAST_A,
    CAST_B,
    WAIT_REL_DONE,
    WAIT_REL_REJ
  } state_t;

  state_t state, state_nxt;

  // Bit 0 is candidate A, bit 1 is candidate B throughout.
  logic [1:0] sync_q1, sync_q2;
  logic [1:0] deb, deb_d, press;
  logic       vote_a_nxt, vote_b_nxt, reject_nxt, ready_nxt;

  // Two-flop synchronizer ahead of all other button logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {btn_b, btn_a};
      sync_q2 <= sync_q1;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync_q2[i] != level) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          level <= ~level;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end

    assign deb[i] = level;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) deb_d <= '0;
    else        deb_d <= deb;
  end

  // Only rising debounced edges count as presses, so a held button never casts.
  assign press = deb & ~deb_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ballot_en) state_nxt = ARMED;
      end
      ARMED: begin
        if (press[0] && !deb[1])      state_nxt = CAST_A;
        else if (press[1] && !deb[0]) state_nxt = CAST_B;
        else if (|press)              state_nxt = WAIT_REL_REJ;
      end
      CAST_A, CAST_B: state_nxt = WAIT_REL_DONE;
      WAIT_REL_DONE: begin
        if (deb == 2'b00) state_nxt = IDLE;
      end
      WAIT_REL_REJ: begin
        if (deb == 2'b00) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase

    vote_a_nxt = (state_nxt == CAST_A);
    vote_b_nxt = (state_nxt == CAST_B);
    reject_nxt = (state == ARMED) && (state_nxt == WAIT_REL_REJ);
    ready_nxt  = (state_nxt == ARMED);
  end

  // Outputs registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vote_a       <= 1'b0;
      vote_b       <= 1'b0;
      reject       <= 1'b0;
      ballot_ready <= 1'b0;
    end else begin
      vote_a       <= vote_a_nxt;
      vote_b       <= vote_b_nxt;
      reject       <= reject_nxt;
      ballot_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_ballot_input_controller.sv
// Directed and random stimulus for ballot_input_controller, checked cycle by cycle
// against a ballot/blocking reference model built from sample-window debounce rules.
module tb_ballot_input_controller;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic reset, btn_a, btn_b, ballot_en;
  logic vote_a, vote_b, ballot_ready, reject;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_va = 0, n_vb = 0, n_rej = 0;

  // Reference model state
  bit raw_a[$], raw_b[$], use_a[$], use_b[$];
  bit mdeb_a, mdeb_b, mprev_a, mprev_b;
  bit granted, blocked, cast_now;
  bit e_va, e_vb, e_rej, e_rdy;

  ballot_input_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_a        (btn_a),
    .btn_b        (btn_b),
    .ballot_en    (ballot_en),
    .vote_a       (vote_a),
    .vote_b       (vote_b),
    .ballot_ready (ballot_ready),
    .reject       (reject)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // True when the last DEB synchronized samples all disagree with the current level.
  function automatic bit flips(input bit q[$], input bit lvl);
    if (q.size() < DEB) return 1'b0;
    for (int k = q.size() - DEB; k < q.size(); k++)
      if (q[k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    raw_a.delete(); raw_b.delete(); use_a.delete(); use_b.delete();
    mdeb_a = 0; mdeb_b = 0; mprev_a = 0; mprev_b = 0;
    granted = 0; blocked = 0; cast_now = 0;
    e_va = 0; e_vb = 0; e_rej = 0; e_rdy = 0;
  endtask

  task automatic model_edge(input bit a, input bit b, input bit en);
    bit pa, pb;
    pa = mdeb_a && !mprev_a;
    pb = mdeb_b && !mprev_b;
    e_va = 0; e_vb = 0; e_rej = 0;
    if (cast_now) begin
      cast_now = 0;
      blocked  = 1;
    end else if (blocked) begin
      if (!mdeb_a && !mdeb_b) blocked = 0;
    end else if (!granted) begin
      if (en) granted = 1;
    end else if (pa || pb) begin
      if (pa && !mdeb_b) begin
        e_va = 1; granted = 0; cast_now = 1;
      end else if (pb && !mdeb_a) begin
        e_vb = 1; granted = 0; cast_now = 1;
      end else begin
        e_rej = 1; blocked = 1;
      end
    end
    e_rdy = granted && !blocked && !cast_now;

    mprev_a = mdeb_a;
    mprev_b = mdeb_b;
    use_a.push_back(raw_a.size() >= 2 ? raw_a[raw_a.size()-2] : 1'b0);
    use_b.push_back(raw_b.size() >= 2 ? raw_b[raw_b.size()-2] : 1'b0);
    raw_a.push_back(a);
    raw_b.push_back(b);
    if (flips(use_a, mdeb_a)) begin mdeb_a = !mdeb_a; use_a.delete(); end
    if (flips(use_b, mdeb_b)) begin mdeb_b = !mdeb_b; use_b.delete(); end
    if (raw_a.size() > 20) begin void'(raw_a.pop_front()); void'(raw_b.pop_front()); end
    if (use_a.size() > 20) void'(use_a.pop_front());
    if (use_b.size() > 20) void'(use_b.pop_front());
  endtask

  // One clock: drive, let the edge happen, advance the model, compare away from the edge.
  task automatic step(input logic a, input logic b, input logic en);
    btn_a = a; btn_b = b; ballot_en = en;
    @(posedge clk);
    cyc++;
    model_edge(a, b, en);
    #1;
    chk_bit("vote_a", vote_a, e_va);
    chk_bit("vote_b", vote_b, e_vb);
    chk_bit("reject", reject, e_rej);
    chk_bit("ballot_ready", ballot_ready, e_rdy);
    if (vote_a === 1'b1) n_va++;
    if (vote_b === 1'b1) n_vb++;
    if (reject === 1'b1) n_rej++;
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0);
  endtask

  task automatic outputs_zero(input string tag);
    chk_bit({tag, "_vote_a"}, vote_a, 1'b0);
    chk_bit({tag, "_vote_b"}, vote_b, 1'b0);
    chk_bit({tag, "_reject"}, reject, 1'b0);
    chk_bit({tag, "_ready"}, ballot_ready, 1'b0);
  endtask

  initial begin
    int va0, vb0, rj0, lat;
    logic ra, rb;

    reset = 1'b0; btn_a = 1'b0; btn_b = 1'b0; ballot_en = 1'b0;
    model_reset();
    #12;
    outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    hold(0, 0, 3);

    // No arm: a press is ignored.
    va0 = n_va;
    hold(1, 0, 12);
    hold(0, 0, 10);
    chk_int("no_arm_votes", n_va - va0, 0);

    // Clean press: vote on the 7th edge counted from the first high sample.
    step(0, 0, 1);
    chk_bit("armed_ready", ballot_ready, 1'b1);
    va0 = n_va; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1, 0, 0);
      if (vote_a === 1'b1 && lat == 0) lat = i;
    end
    chk_int("latency_a", lat, DEB + 3);
    hold(0, 0, 10);
    chk_int("clean_a_votes", n_va - va0, 1);

    // Bouncing B settles into exactly one vote_b.
    step(0, 0, 1);
    va0 = n_va; vb0 = n_vb; rj0 = n_rej;
    for (int i = 0; i < 6; i++) step(0, 1'(i % 2 == 0), 0);
    hold(0, 1, 15);
    hold(0, 0, 10);
    chk_int("bounce_vb", n_vb - vb0, 1);
    chk_int("bounce_va", n_va - va0, 0);
    chk_int("bounce_rej", n_rej - rj0, 0);

    // Simultaneous press rejects, ballot is retained for a clean B.
    step(0, 0, 1);
    va0 = n_va; vb0 = n_vb; rj0 = n_rej;
    hold(1, 1, 12);
    hold(0, 0, 10);
    chk_int("double_rej", n_rej - rj0, 1);
    chk_bit("double_ready_kept", ballot_ready, 1'b1);
    hold(0, 1, 12);
    hold(0, 0, 10);
    chk_int("double_vb", n_vb - vb0, 1);
    chk_int("double_va", n_va - va0, 0);

    // Two presses on one ballot give one vote.
    step(0, 0, 1);
    va0 = n_va;
    hold(1, 0, 12); hold(0, 0, 10);
    hold(1, 0, 12); hold(0, 0, 10);
    chk_int("two_press_one_vote", n_va - va0, 1);

    // Short glitch is filtered.
    step(0, 0, 1);
    va0 = n_va;
    hold(1, 0, DEB - 1);
    hold(0, 0, 10);
    chk_int("glitch_votes", n_va - va0, 0);
    chk_bit("glitch_ready", ballot_ready, 1'b1);
    hold(1, 0, 12); hold(0, 0, 10);

    // Reset mid-press aborts; held button must be released before a later cast.
    step(0, 0, 1);
    va0 = n_va;
    hold(1, 0, DEB + 2);
    reset = 1'b0;
    #1;
    outputs_zero("midreset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    hold(1, 0, 12);
    step(1, 0, 1);
    hold(1, 0, 10);
    chk_int("held_no_vote", n_va - va0, 0);
    hold(0, 0, 8);
    hold(1, 0, 12);
    hold(0, 0, 10);
    chk_int("repress_vote", n_va - va0, 1);

    // Three ballots A, B, A into a downstream tally.
    va0 = n_va; vb0 = n_vb;
    step(0, 0, 1); hold(1, 0, 12); hold(0, 0, 10);
    step(0, 0, 1); hold(0, 1, 12); hold(0, 0, 10);
    step(0, 0, 1); hold(1, 0, 12); hold(0, 0, 10);
    chk_int("tally_a", n_va - va0, 2);
    chk_int("tally_b", n_vb - vb0, 1);

    // Random button activity and arming against the model.
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) ra = ~ra;
      if ($urandom_range(0, 9) == 0) rb = ~rb;
      step(ra, rb, 1'($urandom_range(0, 11) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
